// File: rtl/cwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cwm_pkg : shared constants and types for the CWM phase generator   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cwm_pkg;
  localparam logic signed [15:0] PI_Q      = 16'sd25736;  // pi in Q2.13
  localparam int                 PI_A      = 411775;      // pi in accumulator units (Q2.17)
  localparam int                 TWO_PI_A  = 823550;
  localparam logic [15:0]        LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [15:0]        LFSR_TAPS = 16'hB400;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cwm_state_t;
endpackage
`default_nettype wire

// File: rtl/cwm_lfsr16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cwm_lfsr16 : 16-bit Fibonacci LFSR, exposes its low OUT_W bits     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cwm_lfsr16
  import cwm_pkg::*;
#(
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [OUT_W-1:0] dither
);
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (en) begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  assign dither = r_lfsr[OUT_W-1:0];
endmodule
`default_nettype wire

// File: rtl/cwm_phase_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cwm_phase_gen : wrapped phase accumulator feeding the TX cordic.   |
// | Optional macro PHASE_DITHER_EN adds LFSR dither before truncation. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cwm_phase_gen
  import cwm_pkg::*;
#(
  parameter int PW    = 16,
  parameter int FW    = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PW+FW-1:0] fcw,
  input  logic [PW-1:0]    phase0,
  input  logic [LEN_W-1:0] burst_len,
  output logic [PW-1:0]    theta_out,
  output logic             theta_valid,
  output logic             busy,
  output logic             done
);
  localparam int ACC_W = PW + FW;
  localparam logic signed [ACC_W:0] PI_W     = (ACC_W+1)'(PI_A);
  localparam logic signed [ACC_W:0] TWO_PI_W = (ACC_W+1)'(TWO_PI_A);

  cwm_state_t              state, state_nxt;
  logic signed [ACC_W-1:0] acc, fcw_r, acc_wrapped;
  logic signed [ACC_W:0]   sum, sum_adj;
  logic [LEN_W-1:0]        cnt, len_r;
  logic [PW-1:0]           theta_nxt;
  logic                    launch, abort, last;
  logic                    valid_nxt, done_nxt, step;

  assign launch = (state == IDLE) && start && !stop;
  assign abort  = (state == RUN) && stop;
  assign last   = (state == RUN) && (len_r != '0) && (cnt == len_r - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (abort || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_nxt = (state == RUN) && !stop;
    done_nxt  = abort || last;
    step      = valid_nxt;
  end

  assign busy = (state == RUN);

  // One extra bit of headroom so a step across +/-pi is detectable before folding back.
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {fcw_r[ACC_W-1], fcw_r};
    sum_adj = sum;
    if (sum >= PI_W)       sum_adj = sum - TWO_PI_W;
    else if (sum < -PI_W)  sum_adj = sum + TWO_PI_W;
    acc_wrapped = sum_adj[ACC_W-1:0];
  end

`ifdef PHASE_DITHER_EN
  logic [FW-1:0]         dither;
  logic signed [ACC_W:0] dsum;
  logic signed [PW:0]    dq;

  cwm_lfsr16 #(.OUT_W(FW)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en     (step),
    .dither (dither)
  );

  // Dither can push the top code past pi, so clamp to the largest legal value.
  always_comb begin
    dsum = {acc[ACC_W-1], acc} + {{(PW+1){1'b0}}, dither};
    dq   = dsum[ACC_W:FW];
    if (dq > $signed({PI_Q[PW-1], PI_Q} - 1'b1)) theta_nxt = PI_Q - 1'b1;
    else                                        theta_nxt = dq[PW-1:0];
  end
`else
  always_comb begin
    theta_nxt = acc[ACC_W-1:FW];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      fcw_r       <= '0;
      len_r       <= '0;
      cnt         <= '0;
      theta_out   <= '0;
      theta_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      theta_valid <= valid_nxt;
      done        <= done_nxt;
      if (launch) begin
        acc   <= {phase0, {FW{1'b0}}};
        cnt   <= '0;
        fcw_r <= fcw;
        len_r <= burst_len;
      end else if (step) begin
        theta_out <= theta_nxt;
        acc       <= acc_wrapped;
        cnt       <= cnt + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire
